// File: rtl/mult_div_unit_if.sv
// Request/response bundle between the mult/div unit and its issuing stage.
// The master drives the operation request; the slave returns status and the Hi/Lo result.
interface mult_div_unit_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;

    modport master (
        output start, op, operand_a, operand_b,
        input  busy, done, hi, lo, div_by_zero
    );

    modport slave (
        input  start, op, operand_a, operand_b,
        output busy, done, hi, lo, div_by_zero
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative 32x32 multiply / 32/32 divide unit (signed and unsigned) producing Hi/Lo.
// Works on operand magnitudes for 32 cycles, then applies sign correction in one FIX cycle.
module mult_div_unit (
    input  logic             clk_i,
    input  logic             rst_n_i,
    mult_div_unit_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic        dbz_q, dbz_d;
    logic        is_div_q, neg_a_q, neg_b_q;
    logic [31:0] mag_a_q, mag_b_q;

    logic        load;
    logic        in_div, in_signed, in_neg_a, in_neg_b;
    logic [31:0] in_mag_a, in_mag_b;

    logic [32:0] mul_sum;
    logic [63:0] mul_step;
    logic [32:0] div_shift;
    logic [33:0] div_diff;
    logic [63:0] div_step;
    logic        sign_diff;
    logic [63:0] fix_prod;
    logic [31:0] fix_quot, fix_rem;

    // op[1] selects divide, op[0] selects unsigned
    assign in_div    = bus.op[1];
    assign in_signed = ~bus.op[0];
    assign in_neg_a  = in_signed & bus.operand_a[31];
    assign in_neg_b  = in_signed & bus.operand_b[31];
    assign in_mag_a  = in_neg_a ? (32'd0 - bus.operand_a) : bus.operand_a;
    assign in_mag_b  = in_neg_b ? (32'd0 - bus.operand_b) : bus.operand_b;

    // Multiply: acc = {partial, multiplier}; add multiplicand to the top when LSB set, shift right.
    assign mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? mag_a_q : 32'd0)};
    assign mul_step = {mul_sum, acc_q[31:1]};

    // Restoring divide: acc = {remainder, dividend/quotient}; quotient bits shift in at the LSB.
    assign div_shift = {acc_q[63:32], acc_q[31]};
    assign div_diff  = {1'b0, div_shift} - {2'b00, mag_b_q};
    assign div_step  = div_diff[33] ? {div_shift[31:0], acc_q[30:0], 1'b0}
                                    : {div_diff[31:0],  acc_q[30:0], 1'b1};

    // Remainder follows the dividend's sign; quotient/product follow the sign difference.
    assign sign_diff = neg_a_q ^ neg_b_q;
    assign fix_prod  = sign_diff ? (64'd0 - acc_q) : acc_q;
    assign fix_quot  = sign_diff ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
    assign fix_rem   = neg_a_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dbz_d   = 1'b0;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    load  = 1'b1;
                    cnt_d = 6'd0;
                    acc_d = {32'd0, (in_div ? in_mag_a : in_mag_b)};
                    if (in_div && (bus.operand_b == 32'd0)) begin
                        hi_d    = bus.operand_a;
                        lo_d    = 32'hFFFF_FFFF;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                acc_d = is_div_q ? div_step : mul_step;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                hi_d    = is_div_q ? fix_rem  : fix_prod[63:32];
                lo_d    = is_div_q ? fix_quot : fix_prod[31:0];
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
            acc_q   <= 64'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dbz_q   <= dbz_d;
        end
    end

    // Operation context captured once at Start; bus changes afterwards are ignored.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            is_div_q <= 1'b0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            mag_a_q  <= 32'd0;
            mag_b_q  <= 32'd0;
        end else if (load) begin
            is_div_q <= in_div;
            neg_a_q  <= in_neg_a;
            neg_b_q  <= in_neg_b;
            mag_a_q  <= in_mag_a;
            mag_b_q  <= in_mag_b;
        end
    end

    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = (state_q == DONE);
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes expected Hi/Lo/flag/latency,
// a negedge monitor pops and compares whenever Done is seen.
module tb_mult_div_unit;
    localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          lat;
        int          start_edge;
    } exp_t;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic [31:0] last_hi = 32'd0, last_lo = 32'd0;
    bit   skip_hold = 1'b1;

    mult_div_unit_if bif ();

    mult_div_unit dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bif.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge rst_n) skip_hold = 1'b1;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endfunction

    // Monitor: every Done cycle must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bif.done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk({mon_e.name, "_hi"}, bif.hi, mon_e.hi);
                    chk({mon_e.name, "_lo"}, bif.lo, mon_e.lo);
                    chk({mon_e.name, "_dbz"}, {31'd0, bif.div_by_zero}, {31'd0, mon_e.dbz});
                    chk({mon_e.name, "_latency"}, cyc - mon_e.start_edge + 1, mon_e.lat);
                    chk({mon_e.name, "_busy_in_done"}, {31'd0, bif.busy}, 32'd1);
                end
            end else begin
                chk("dbz_outside_done", {31'd0, bif.div_by_zero}, 32'd0);
                if (!skip_hold) begin
                    chk("hi_hold", bif.hi, last_hi);
                    chk("lo_hold", bif.lo, last_lo);
                end
            end
            skip_hold = 1'b0;
        end
        last_hi = bif.hi;
        last_lo = bif.lo;
    end

    // Called at a negedge: Start is sampled on the following rising edge.
    task automatic start_op(input string name, input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                            input bit track);
        exp_t e;
        bit   dz;
        dz = op[1] && (b == 32'd0);
        bif.start     = 1'b1;
        bif.op        = op;
        bif.operand_a = a;
        bif.operand_b = b;
        if (track) begin
            e.name = name; e.hi = eh; e.lo = el; e.dbz = dz;
            e.lat = dz ? 1 : 34; e.start_edge = cyc + 1;
            sb.push_back(e);
        end
        @(negedge clk);
        bif.start     = 1'b0;
        bif.op        = op ^ 2'b01;
        bif.operand_a = ~a;
        bif.operand_b = b + 32'd3;
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !bif.busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            chk({name, "_timeout"}, 32'd1, 32'd0);
            sb.delete();
        end
    endtask

    vec_t vecs[$];

    initial begin
        vecs.push_back('{"mult_neg3x7",   OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB});
        vecs.push_back('{"multu_max",     OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001});
        vecs.push_back('{"div_neg7by2",   OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD});
        vecs.push_back('{"divu_100by7",   OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14});
        vecs.push_back('{"divu_by0",      OP_DIVU,  32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF});
        vecs.push_back('{"div_minbyneg1", OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000});
        vecs.push_back('{"mult_xneg1",    OP_MULT,  32'h00001234, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFEDCC});
        vecs.push_back('{"div_7byneg2",   OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD});
        vecs.push_back('{"div_by0",       OP_DIV,   32'h80000000, 32'h00000000, 32'h80000000, 32'hFFFFFFFF});
        vecs.push_back('{"mult_neg3xneg5",OP_MULT,  32'hFFFFFFFD, 32'hFFFFFFFB, 32'h00000000, 32'h0000000F});
        vecs.push_back('{"divu_maxby16",  OP_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF});

        bif.start = 1'b0; bif.op = 2'b00; bif.operand_a = 32'd0; bif.operand_b = 32'd0;
        repeat (3) @(negedge clk);
        chk("reset_busy", {31'd0, bif.busy}, 32'd0);
        chk("reset_done", {31'd0, bif.done}, 32'd0);
        chk("reset_dbz",  {31'd0, bif.div_by_zero}, 32'd0);
        chk("reset_hi",   bif.hi, 32'd0);
        chk("reset_lo",   bif.lo, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            start_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, 1'b1);
            wait_idle(vecs[i].name);
            $display("txn %s op=%b a=%h b=%h", vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b);
        end

        // Starts in cycle 5 and in the DONE cycle are ignored; cycle 35 is accepted back-to-back.
        start_op("multu_ignore", OP_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b1);
        repeat (4) @(negedge clk);
        bif.start = 1'b1; bif.op = OP_DIVU; bif.operand_a = 32'd5; bif.operand_b = 32'd0;
        @(negedge clk);
        bif.start = 1'b0;
        repeat (28) @(negedge clk);
        bif.start = 1'b1; bif.op = OP_MULT; bif.operand_a = 32'd1; bif.operand_b = 32'd1;
        @(negedge clk);
        start_op("divu_b2b", OP_DIVU, 32'd1000, 32'd7, 32'd6, 32'd142, 1'b1);
        wait_idle("ignore_b2b");
        $display("txn ignore_start_and_back_to_back");

        // Reset in cycle 10 aborts the MULT; the Start on the release edge completes normally.
        start_op("mult_aborted", OP_MULT, 32'hFFFFFFFD, 32'h00000007, 32'd0, 32'd0, 1'b0);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset_busy", {31'd0, bif.busy}, 32'd0);
        chk("midreset_done", {31'd0, bif.done}, 32'd0);
        chk("midreset_hi",   bif.hi, 32'd0);
        chk("midreset_lo",   bif.lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        start_op("multu_after_rst", OP_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 1'b1);
        wait_idle("after_reset");
        $display("txn reset_abort_then_restart");

        repeat (40) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have: Clock  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have: Reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have: Start  input  1  request to begin an operation; sampled only in IDLE.
REQ-004 SHALL have: Op  input  2  operation select: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
REQ-005 SHALL have: Operand_A  input  32  rs value from register file Read_Data1; multiplicand / dividend.
REQ-006 SHALL have: Operand_B  input  32  rt value from register file Read_Data2; multiplier / divisor.
REQ-007 SHALL have: Busy  output  1  high whenever state is not IDLE.
REQ-008 SHALL have: Done  output  1  one-cycle pulse; Hi/Lo hold the new result.
REQ-009 SHALL have: Hi  output  32  multiply: upper product word; divide: remainder.
REQ-010 SHALL have: Lo  output  32  multiply: lower product word; divide: quotient.
REQ-011 SHALL have: Div_By_Zero  output  1  high together with Done when a divide had Operand_B = 0.

Function
REQ-012 SHALL implement states IDLE, CALC, FIX, DONE.
REQ-013 IDLE: on an edge with Start=1, SHALL latch Op, Operand_A and Operand_B, clear the iteration counter, and go to CALC; for a divide with Operand_B=0, SHALL go directly to DONE instead.
REQ-014 CALC SHALL perform one iteration per cycle for exactly 32 cycles:
  - multiply: radix-2 shift-add on operand magnitudes into a 64-bit accumulator;
  - divide: restoring division on operand magnitudes.
REQ-015 Counter: 6-bit; CALC SHALL exit to FIX on the edge where the counter reaches 31.
REQ-016 FIX (1 cycle) SHALL apply sign correction for signed Op; unsigned Op SHALL pass the result unchanged.
  - MULT: negate the 64-bit product when the operand signs differ.
  - DIV: negate the quotient when the operand signs differ; the remainder SHALL take the sign of the dividend.
REQ-017 Hi and Lo SHALL update only on the edge entering DONE and SHALL hold their value at all other times.
REQ-018 DONE SHALL assert Done=1 for exactly one cycle, then return to IDLE unconditionally.
REQ-019 Latency: Start sampled at edge 0 -> CALC during cycles 1..32, FIX in cycle 33, Done high in cycle 34.
  - Divide by zero: Done high in cycle 1.
REQ-020 Divide by zero SHALL produce Hi = Operand_A, Lo = 0xFFFFFFFF, Div_By_Zero=1 in the Done cycle; Div_By_Zero SHALL be 0 in every other cycle.
REQ-021 Signed DIV of 0x80000000 by 0xFFFFFFFF SHALL give Lo=0x80000000, Hi=0x00000000, with no error flag.
REQ-022 Start SHALL be ignored while Busy=1, including in the DONE cycle.
  - Changes on Op/Operand_A/Operand_B during an operation SHALL NOT affect the result.
REQ-023 A new Start accepted in the IDLE cycle after DONE SHALL begin a new operation without any dead cycle.
REQ-024 All arithmetic SHALL be modulo 2^32 per output word; no overflow or exception output beyond Div_By_Zero.

Reset
REQ-025 Reset_n=0 SHALL immediately force:
  - state = IDLE, counter = 0;
  - Busy=0, Done=0, Div_By_Zero=0;
  - Hi=0x00000000, Lo=0x00000000.
REQ-026 Reset asserted mid-operation (CALC or FIX) SHALL abort the operation; no Done pulse and no Hi/Lo update SHALL follow.
REQ-027 After Reset_n deasserts, the first rising edge with Start=1 SHALL be accepted.

Verification
REQ-028 MULT A=0xFFFFFFFD (-3), B=0x00000007 -> Done in cycle 34, Hi=0xFFFFFFFF, Lo=0xFFFFFFEB.
REQ-029 MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001.
REQ-030 DIV A=0xFFFFFFF9 (-7), B=0x00000002 -> Lo=0xFFFFFFFD (-3), Hi=0xFFFFFFFF (-1); DIVU A=100, B=7 -> Lo=14, Hi=2.
REQ-031 DIVU A=0x00000064, B=0 -> Done in cycle 1, Div_By_Zero=1, Hi=0x00000064, Lo=0xFFFFFFFF.
REQ-032 Start a MULT, pulse Reset_n low in cycle 10 -> Busy=0 and Hi=Lo=0 immediately; no Done pulse follows; the next Start completes normally.
REQ-033 Pulse Start again with new operands in cycles 5 and 34 of a running operation -> both ignored; the result matches the original operands; back-to-back Start in cycle 35 is accepted.
